seq_calc: RTL

SEQ_CALC -- requirements
Module: seq_calc

---
 rtl/seq_calc.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/seq_calc.sv
// Sequential calculator: add/sub in one cycle, restoring divide over WIDTH cycles.
// Define SEQ_CALC_SEQ_MULT_EN for a shift-add multiplier over WIDTH cycles instead of a single-cycle product.
module seq_calc #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               add,
  input  logic               sub,
  input  logic               mult,
  input  logic               div,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  output logic [2*WIDTH-1:0] ans,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [W2-1:0]    r_ans;
  logic             r_err;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;

  logic [3:0]       w_opc;
  logic             w_onehot;
  logic             w_go_run;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [W2-1:0]    w_result;

`ifdef SEQ_CALC_SEQ_MULT_EN
  logic             r_is_mult;
  logic [W2-1:0]    r_acc;
  logic [W2-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [W2-1:0]    w_acc_next;
`endif

  assign w_opc    = {add, mult, sub, div};
  assign w_onehot = (w_opc != 4'b0) && ((w_opc & (w_opc - 4'd1)) == 4'b0);

`ifdef SEQ_CALC_SEQ_MULT_EN
  assign w_go_run = w_onehot && (mult || (div && (op2 != '0)));
`else
  assign w_go_run = w_onehot && div && (op2 != '0);
`endif

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_dvs});
  assign w_rem_next = w_ge ? (w_shift[WIDTH-1:0] - r_dvs) : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

`ifdef SEQ_CALC_SEQ_MULT_EN
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_result   = r_is_mult ? w_acc_next : {w_rem_next, w_quo_next};
`else
  assign w_result   = {w_rem_next, w_quo_next};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = w_go_run ? RUN : FIN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = FIN;
        end
      end
      FIN: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ans    <= '0;
      r_err    <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
`ifdef SEQ_CALC_SEQ_MULT_EN
      r_is_mult <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
`endif
    end else if (w_accept) begin
      r_dvs <= op2;
      r_quo <= op1;
      r_rem <= '0;
      r_cnt <= '0;
`ifdef SEQ_CALC_SEQ_MULT_EN
      r_is_mult <= mult;
      r_acc     <= '0;
      r_mcand   <= W2'(op1);
      r_mplier  <= op2;
`endif
      // Single-cycle results land in ans on the accepting edge itself.
      if (!w_go_run) begin
        r_err <= 1'b0;
        if (!w_onehot) begin
          r_ans <= '0;
          r_err <= 1'b1;
        end else if (add) begin
          r_ans <= W2'(op1) + W2'(op2);
        end else if (sub) begin
          r_ans <= W2'(op1) - W2'(op2);
`ifndef SEQ_CALC_SEQ_MULT_EN
        end else if (mult) begin
          r_ans <= W2'(op1) * W2'(op2);
`endif
        end else begin
          r_ans <= {op1, {WIDTH{1'b1}}};
          r_err <= 1'b1;
        end
      end
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + CW'(1);
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
`ifdef SEQ_CALC_SEQ_MULT_EN
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
`endif
      if (w_last) begin
        r_ans <= w_result;
        r_err <= 1'b0;
      end
    end
  end

  assign ans = r_ans;
  assign err = r_err;

endmodule
